// File: rtl/lfsr_stream_decryptor.sv
// -----------------------------------------------------------------------------
// lfsr_stream_decryptor
//
// Purpose
//   Receive end of the 7-bit LFSR stream cipher. Each message starts with a
//   known plaintext preamble of PRE_LEN bytes of PAD. Byte 0 gives the seed
//   directly. Bytes 1..PRE_LEN-1 are used to work out which of the nine
//   candidate tap patterns produced the stream. After that, every remaining
//   byte is decrypted with the candidate that was locked.
//
//   LFSR step:  next = {s[5:0], ^(s & tap)}
//   Byte k is encrypted with step^k(seed).
//
// Ports
//   Clk        in   1  clock, posedge
//   Reset_n    in   1  asynchronous active-low reset
//   Start      in   1  one-cycle pulse; abandon message, go to SEED
//   In_Valid   in   1  ciphertext byte valid
//   In_Ready   out  1  block accepts In_Data this cycle
//   In_Data    in   8  ciphertext byte (bit 7 ignored)
//   In_Last    in   1  final byte of message
//   Out_Valid  out  1  plaintext byte valid
//   Out_Ready  in   1  consumer accepts Out_Data
//   Out_Data   out  8  plaintext byte, bit 7 always 0
//   Out_Last   out  1  plaintext byte that came from the In_Last byte
//   Err        out  1  sticky: no candidate survived, or early In_Last
//
// Optional build macro LFSR_DEC_STATUS_EN adds:
//   Locked     out  1  high from DECRYPT entry until return to IDLE
//   Tap_Idx    out  4  locked candidate index 0..8
//   Seed       out  7  recovered seed
//
// State table
//   state     | meaning
//   S_IDLE    | waiting for Start, input not accepted
//   S_SEED    | waiting for byte 0, recovers seed
//   S_HUNT    | checking preamble bytes against all candidates
//   S_DECRYPT | decrypting payload with the locked candidate
// -----------------------------------------------------------------------------
module lfsr_stream_decryptor #(
  parameter int unsigned PRE_LEN = 8,
  parameter logic [7:0]  PAD     = 8'h20,
  parameter logic [62:0] TAPS    = {7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                    7'h69, 7'h5C, 7'h7E, 7'h7B}
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic       In_Valid,
  output logic       In_Ready,
  input  logic [7:0] In_Data,
  input  logic       In_Last,
  output logic       Out_Valid,
  input  logic       Out_Ready,
  output logic [7:0] Out_Data,
  output logic       Out_Last,
  output logic       Err
`ifdef LFSR_DEC_STATUS_EN
  ,
  output logic       Locked,
  output logic [3:0] Tap_Idx,
  output logic [6:0] Seed
`endif
);

  localparam int NCAND = 9;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEED    = 2'd1,
    S_HUNT    = 2'd2,
    S_DECRYPT = 2'd3
  } state_t;

  function automatic logic [6:0] f_step(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  state_t           r_state;
  logic [6:0]       r_cand [NCAND];
  logic [NCAND-1:0] r_mask;
  logic [5:0]       r_count;
  logic [6:0]       r_lock_state;
  logic [3:0]       r_lock_idx;
  logic             r_out_valid;
  logic [7:0]       r_out_data;
  logic             r_out_last;
  logic             r_err;
  logic             r_last_seen;

  logic [6:0]       w_key;
  logic [6:0]       w_seed_step [NCAND];
  logic [6:0]       w_cand_step [NCAND];
  logic [NCAND-1:0] w_miss;
  logic [NCAND-1:0] w_mask_next;
  logic [3:0]       w_lock_idx;
  logic [6:0]       w_lock_state;
  logic [6:0]       w_run_tap;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [5:0]       w_count_inc;
  logic             w_pre_done;
  logic             w_seed_now;
  logic             w_hunt_xfer;
  logic             w_lock_now;
  logic             w_fail_now;
  logic             w_done_now;
  logic             w_unused_msb;

  // The ciphertext MSB carries no key material.
  assign w_unused_msb = In_Data[7];

  // Expected LFSR state for the current byte if it is a preamble byte.
  assign w_key = In_Data[6:0] ^ PAD[6:0];

  for (genvar gi = 0; gi < NCAND; gi++) begin : g_cand
    // Candidate 0 is the leftmost (most significant) entry of TAPS.
    localparam logic [6:0] TAP = TAPS[(NCAND-1-gi)*7 +: 7];
    assign w_seed_step[gi] = f_step(w_key, TAP);
    assign w_cand_step[gi] = f_step(r_cand[gi], TAP);
    assign w_miss[gi]      = (r_cand[gi] != w_key);
  end

  assign w_mask_next = r_mask & ~w_miss;

  // Lowest surviving index wins; scanning downward leaves the lowest in place.
  always_comb begin
    w_lock_idx   = 4'd0;
    w_lock_state = 7'd0;
    for (int i = NCAND-1; i >= 0; i--) begin
      if (w_mask_next[i]) begin
        w_lock_idx   = 4'(i);
        w_lock_state = w_cand_step[i];
      end
    end
  end

  always_comb begin
    w_run_tap = 7'd0;
    for (int i = 0; i < NCAND; i++) begin
      if (r_lock_idx == 4'(i)) begin
        w_run_tap = TAPS[(NCAND-1-i)*7 +: 7];
      end
    end
  end

  // Once the In_Last byte is taken the message is closed, so input stays
  // blocked while that final plaintext byte waits to drain.
  always_comb begin
    case (r_state)
      S_SEED, S_HUNT: In_Ready = 1'b1;
      S_DECRYPT:      In_Ready = !r_last_seen && (!r_out_valid || Out_Ready);
      default:        In_Ready = 1'b0;
    endcase
  end

  assign w_in_xfer   = In_Valid & In_Ready;
  assign w_out_xfer  = r_out_valid & Out_Ready;
  assign w_count_inc = r_count + 6'd1;
  assign w_pre_done  = (w_count_inc == 6'(PRE_LEN));

  // Start overrides any transfer in the same cycle.
  assign w_seed_now  = !Start && (r_state == S_SEED) && w_in_xfer;
  assign w_hunt_xfer = !Start && (r_state == S_HUNT) && w_in_xfer;
  assign w_fail_now  = w_hunt_xfer && (In_Last || (w_pre_done && (w_mask_next == '0)));
  assign w_lock_now  = w_hunt_xfer && !In_Last && w_pre_done && (w_mask_next != '0);
  assign w_done_now  = !Start && (r_state == S_DECRYPT) && w_out_xfer && r_out_last;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= S_IDLE;
      for (int i = 0; i < NCAND; i++) r_cand[i] <= 7'd0;
      r_mask       <= '1;
      r_count      <= 6'd0;
      r_lock_state <= 7'd0;
      r_lock_idx   <= 4'd0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 8'd0;
      r_out_last   <= 1'b0;
      r_err        <= 1'b0;
      r_last_seen  <= 1'b0;
    end else if (Start) begin
      r_state     <= S_SEED;
      r_mask      <= '1;
      r_count     <= 6'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
      r_last_seen <= 1'b0;
    end else begin
      case (r_state)
        S_SEED: begin
          if (w_seed_now) begin
            r_cand  <= w_seed_step;
            r_mask  <= '1;
            r_count <= 6'd1;
            r_state <= S_HUNT;
          end
        end
        S_HUNT: begin
          if (w_hunt_xfer) begin
            r_cand  <= w_cand_step;
            r_mask  <= w_mask_next;
            r_count <= w_count_inc;
            if (w_fail_now) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else if (w_lock_now) begin
              r_lock_idx   <= w_lock_idx;
              r_lock_state <= w_lock_state;
              r_state      <= S_DECRYPT;
            end
          end
        end
        S_DECRYPT: begin
          if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
          if (w_done_now) begin
            r_state     <= S_IDLE;
            r_last_seen <= 1'b0;
          end
          // A new byte may arrive in the same cycle the previous one drains.
          if (w_in_xfer) begin
            r_out_data   <= {1'b0, In_Data[6:0] ^ r_lock_state};
            r_out_valid  <= 1'b1;
            r_out_last   <= In_Last;
            r_last_seen  <= In_Last;
            r_lock_state <= f_step(r_lock_state, w_run_tap);
          end
        end
        default: ;
      endcase
    end
  end

  assign Out_Valid = r_out_valid;
  assign Out_Data  = r_out_data;
  assign Out_Last  = r_out_last;
  assign Err       = r_err;

`ifdef LFSR_DEC_STATUS_EN
  logic       r_locked;
  logic [6:0] r_seed;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_locked <= 1'b0;
      r_seed   <= 7'd0;
    end else if (Start) begin
      r_locked <= 1'b0;
    end else begin
      if (w_seed_now) r_seed <= w_key;
      if (w_lock_now) r_locked <= 1'b1;
      if (w_done_now) r_locked <= 1'b0;
    end
  end

  assign Locked  = r_locked;
  assign Tap_Idx = r_lock_idx;
  assign Seed    = r_seed;
`endif

endmodule

// File: tb/tb_lfsr_stream_decryptor.sv
module tb_lfsr_stream_decryptor;

  localparam int PRE = 8;
  localparam logic [6:0] TT [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                    7'h69, 7'h5C, 7'h7E, 7'h7B};

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Start = 1'b0;
  logic       In_Valid = 1'b0;
  logic       In_Ready;
  logic [7:0] In_Data = 8'd0;
  logic       In_Last = 1'b0;
  logic       Out_Valid;
  logic       Out_Ready = 1'b1;
  logic [7:0] Out_Data;
  logic       Out_Last;
  logic       Err;
`ifdef LFSR_DEC_STATUS_EN
  logic       Locked;
  logic [3:0] Tap_Idx;
  logic [6:0] Seed;
`endif

  lfsr_stream_decryptor dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Data   (In_Data),
    .In_Last   (In_Last),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Data  (Out_Data),
    .Out_Last  (Out_Last),
    .Err       (Err)
`ifdef LFSR_DEC_STATUS_EN
    ,
    .Locked    (Locked),
    .Tap_Idx   (Tap_Idx),
    .Seed      (Seed)
`endif
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct { logic [7:0] d; logic l; } exp_t;
  exp_t sbq[$];
  int   stall_cnt = 0;
  int   n_popped = 0;

  typedef struct {
    string      name;
    logic [6:0] tap;
    logic [6:0] seed;
    int         n;
    int         corrupt_at;
    int         last_at;
  } vec_t;
  vec_t vt[7];

  string      pay = "Hi!\nLFSR stream ok, 0123456789";
  logic [7:0] ct   [64];
  logic [7:0] expd [64];
  int         lock_i;
  logic [6:0] seedr;
  bit         exp_err;
  int         n_send;

  task automatic chk(input bit ok, input string nm, input int act, input int req);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [6:0] stp(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  // Encrypt the vector's message and derive the expected decoder behaviour by
  // replaying every candidate over the whole preamble independently.
  task automatic load_vec(input int v);
    logic [6:0] st;
    logic [7:0] p;
    bit         ok;
    st = vt[v].seed;
    for (int k = 0; k < vt[v].n; k++) begin
      p = (k < PRE) ? 8'h20 : 8'(pay[k-PRE]);
      ct[k] = {1'($urandom_range(0, 1)), p[6:0] ^ st};
      if (k == vt[v].corrupt_at) ct[k] = 8'h00;
      st = stp(st, vt[v].tap);
    end
    seedr  = ct[0][6:0] ^ 7'h20;
    lock_i = -1;
    for (int i = 0; i < 9; i++) begin
      st = seedr;
      ok = 1'b1;
      for (int k = 1; k < PRE; k++) begin
        st = stp(st, TT[i]);
        if ((ct[k][6:0] ^ 7'h20) != st) ok = 1'b0;
      end
      if (ok && lock_i < 0) lock_i = i;
    end
    exp_err = (vt[v].last_at >= 0 && vt[v].last_at < PRE) || (lock_i < 0);
    if (vt[v].last_at >= 0 && vt[v].last_at < PRE) n_send = vt[v].last_at + 1;
    else if (exp_err)                              n_send = PRE;
    else                                           n_send = vt[v].n;
    if (lock_i >= 0) begin
      st = seedr;
      for (int k = 1; k < vt[v].n; k++) begin
        st = stp(st, TT[lock_i]);
        expd[k] = {1'b0, ct[k][6:0] ^ st};
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input bit push, input logic [7:0] pd);
    int n;
    exp_t e;
    @(negedge Clk);
    In_Valid = 1'b1;
    In_Data  = d;
    In_Last  = l;
    #1;
    n = 0;
    while (!In_Ready && n < 200) begin
      @(negedge Clk);
      #1;
      n++;
    end
    if (!In_Ready) begin
      chk(1'b0, "in_ready_timeout", 0, 1);
      In_Valid = 1'b0;
      return;
    end
    if (push) begin
      e.d = pd;
      e.l = l;
      sbq.push_back(e);
    end
    @(posedge Clk);
    #1;
    In_Valid = 1'b0;
    In_Last  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    sbq.delete();
  endtask

  task automatic run_vector(input int v, input bit do_start);
    logic l;
    load_vec(v);
    if (do_start) pulse_start();
    for (int k = 0; k < n_send; k++) begin
      l = (k == vt[v].n - 1) || (k == vt[v].last_at);
      send_byte(ct[k], l, !exp_err && k >= PRE, expd[k]);
`ifdef LFSR_DEC_STATUS_EN
      if (k == PRE - 1 && !exp_err) begin
        chk(Locked == 1'b1, {vt[v].name, "_locked"}, Locked, 1);
        chk(Tap_Idx == 4'(lock_i), {vt[v].name, "_tap_idx"}, Tap_Idx, lock_i);
        chk(Seed == seedr, {vt[v].name, "_seed"}, Seed, seedr);
      end
`endif
    end
    if (exp_err) begin
      chk(Err == 1'b1, {vt[v].name, "_err"}, Err, 1);
      chk(In_Ready == 1'b0, {vt[v].name, "_idle_after_err"}, In_Ready, 0);
    end else begin
      for (int i = 0; i < 300 && sbq.size() > 0; i++) @(negedge Clk);
      chk(sbq.size() == 0, {vt[v].name, "_drain"}, sbq.size(), 0);
      @(posedge Clk);
      #1;
      chk(Err == 1'b0, {vt[v].name, "_no_err"}, Err, 0);
      chk(In_Ready == 1'b0, {vt[v].name, "_idle_after_last"}, In_Ready, 0);
      chk(Out_Valid == 1'b0, {vt[v].name, "_out_idle"}, Out_Valid, 0);
`ifdef LFSR_DEC_STATUS_EN
      chk(Locked == 1'b0, {vt[v].name, "_unlocked"}, Locked, 0);
`endif
    end
  endtask

  // Consumer backpressure: Out_Ready low while stall_cnt is non-zero.
  initial begin
    forever begin
      @(negedge Clk);
      if (stall_cnt > 0) begin
        Out_Ready = 1'b0;
        stall_cnt--;
      end else begin
        Out_Ready = 1'b1;
      end
    end
  end

  // Output monitor: checks each output transfer against the scoreboard and
  // the hold behaviour while the consumer stalls.
  initial begin
    bit         prev_stall;
    logic [7:0] prev_data;
    exp_t       e;
    prev_stall = 1'b0;
    prev_data  = 8'd0;
    forever begin
      @(negedge Clk);
      #2;
      if (!Reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && Out_Valid) chk(Out_Data == prev_data, "hold_data", Out_Data, prev_data);
        if (Out_Valid && !Out_Ready) chk(In_Ready == 1'b0, "stall_in_ready", In_Ready, 0);
        prev_stall = Out_Valid && !Out_Ready;
        prev_data  = Out_Data;
        if (Out_Valid && Out_Ready) begin
          if (sbq.size() == 0) begin
            chk(sbq.size() != 0, "unexpected_out", {Out_Last, Out_Data}, 0);
          end else begin
            e = sbq.pop_front();
            chk(Out_Data == e.d && Out_Last == e.l, "out_byte", {Out_Last, Out_Data}, {e.l, e.d});
            n_popped++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    vt[0] = '{"t1",        7'h60, 7'h01, 12, -1, -1};
    vt[1] = '{"t2",        7'h48, 7'h01, 14, -1, -1};
    vt[2] = '{"t3",        7'h60, 7'h01, 12,  3, -1};
    vt[3] = '{"t_6a",      7'h6A, 7'h3C, 20, -1, -1};
    vt[4] = '{"t5_7b",     7'h7B, 7'h55, 16, -1, -1};
    vt[5] = '{"early_last",7'h5C, 7'h7F, 12, -1,  4};
    vt[6] = '{"one_byte",  7'h72, 7'h11,  9, -1, -1};

    // Reset values
    #2;
    chk(Out_Valid == 1'b0, "rst_out_valid", Out_Valid, 0);
    chk(Out_Data == 8'd0, "rst_out_data", Out_Data, 0);
    chk(Out_Last == 1'b0, "rst_out_last", Out_Last, 0);
    chk(Err == 1'b0, "rst_err", Err, 0);
    chk(In_Ready == 1'b0, "rst_in_ready", In_Ready, 0);
`ifdef LFSR_DEC_STATUS_EN
    chk(Locked == 1'b0, "rst_locked", Locked, 0);
    chk(Tap_Idx == 4'd0, "rst_tap_idx", Tap_Idx, 0);
    chk(Seed == 7'd0, "rst_seed", Seed, 0);
`endif
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    #1;
    chk(In_Ready == 1'b0, "idle_in_ready", In_Ready, 0);

    // Table of messages
    for (int v = 0; v < 7; v++) run_vector(v, 1'b1);

    // Output backpressure mid-DECRYPT
    base = n_popped;
    fork
      run_vector(3, 1'b1);
      begin
        for (int i = 0; i < 400 && n_popped < base + 2; i++) @(negedge Clk);
        stall_cnt = 5;
      end
    join

    // Start during DECRYPT with a pending output, then a new message
    load_vec(1);
    pulse_start();
    for (int k = 0; k < PRE; k++) send_byte(ct[k], 1'b0, 1'b0, 8'd0);
    stall_cnt = 50;
    send_byte(ct[PRE], 1'b0, 1'b1, expd[PRE]);
    @(negedge Clk);
    #2;
    chk(Out_Valid == 1'b1, "t5_pending", Out_Valid, 1);
    pulse_start();
    chk(Out_Valid == 1'b0, "t5_dropped", Out_Valid, 0);
    chk(In_Ready == 1'b1, "t5_seed_ready", In_Ready, 1);
    stall_cnt = 0;
    run_vector(4, 1'b0);

    // Reset mid-HUNT
    load_vec(0);
    pulse_start();
    for (int k = 0; k < 4; k++) send_byte(ct[k], 1'b0, 1'b0, 8'd0);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk(In_Ready == 1'b0, "t6_in_ready", In_Ready, 0);
    chk(Out_Valid == 1'b0, "t6_out_valid", Out_Valid, 0);
    chk(Err == 1'b0, "t6_err", Err, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    sbq.delete();
    run_vector(0, 1'b1);

    // Reset with a plaintext byte pending
    load_vec(1);
    pulse_start();
    for (int k = 0; k < PRE; k++) send_byte(ct[k], 1'b0, 1'b0, 8'd0);
    stall_cnt = 50;
    send_byte(ct[PRE], 1'b0, 1'b1, expd[PRE]);
    @(negedge Clk);
    Reset_n = 1'b0;
    sbq.delete();
    #1;
    chk(Out_Valid == 1'b0, "rst_pend_out_valid", Out_Valid, 0);
    chk(Out_Data == 8'd0, "rst_pend_out_data", Out_Data, 0);
    chk(In_Ready == 1'b0, "rst_pend_in_ready", In_Ready, 0);
    stall_cnt = 0;
    @(negedge Clk);
    Reset_n = 1'b1;
    run_vector(6, 1'b1);

    // Err must clear on Start
    run_vector(2, 1'b1);
    pulse_start();
    chk(Err == 1'b0, "start_clears_err", Err, 0);

    repeat (3) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
